// File: rtl/rv32_pkg.sv
// ============================================================================
// Module      : rv32_pkg
// Description : Shared MMIO address constants and the register decode used by
//               the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32_pkg;

  // MMIO window base and per-register byte offsets
  localparam logic [31:0] c_mmio_base       = 32'h1000_0000;
  localparam logic [31:0] c_off_con_data    = 32'h0000_0000;
  localparam logic [31:0] c_off_con_status  = 32'h0000_0004;
  localparam logic [31:0] c_off_cycle       = 32'h0000_0008;
  localparam logic [31:0] c_off_drops       = 32'h0000_000C;

  typedef enum logic [2:0] {
    REG_NONE       = 3'd0,
    REG_RAM        = 3'd1,
    REG_CON_DATA   = 3'd2,
    REG_CON_STATUS = 3'd3,
    REG_CYCLE      = 3'd4,
    REG_DROPS      = 3'd5
  } mmio_reg_e;

  // Word-granular decode: the two low address bits never take part
  function automatic mmio_reg_e decode_addr(input logic [31:0] addr,
                                            input int unsigned ram_words);
    logic [31:0] word_addr;
    mmio_reg_e   sel;
    word_addr = {addr[31:2], 2'b00};
    sel       = REG_NONE;
    if (word_addr < (ram_words << 2))
      sel = REG_RAM;
    else if (word_addr == c_mmio_base + c_off_con_data)
      sel = REG_CON_DATA;
    else if (word_addr == c_mmio_base + c_off_con_status)
      sel = REG_CON_STATUS;
    else if (word_addr == c_mmio_base + c_off_cycle)
      sel = REG_CYCLE;
    else if (word_addr == c_mmio_base + c_off_drops)
      sel = REG_DROPS;
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with push/pop/full/empty/count. A push into
//               a full FIFO is accepted when a pop happens in the same cycle.
//               Head data reads as zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int c_pw = $clog2(DEPTH);
  localparam int c_cw = c_pw + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_pw-1:0]  r_wptr;
  logic [c_pw-1:0]  r_rptr;
  logic [c_cw-1:0]  r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == c_cw'(DEPTH));
  assign count     = r_count;
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign rdata     = empty ? '0 : r_mem[r_rptr];

  // Storage array; pointers alone define validity so no reset is needed
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= wdata;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + c_pw'(1);
      if (w_do_pop)  r_rptr <= r_rptr + c_pw'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + c_cw'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - c_cw'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Zero-latency data-memory responder for a single-cycle core:
//               word RAM plus MMIO console FIFO, cycle counter and drop count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
  import rv32_pkg::*;
#(
  parameter int RAM_WORDS = 1024,
  parameter int CON_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic        dmem_we,
  output logic [31:0] dmem_rdata,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready
);

  localparam int c_ram_aw = $clog2(RAM_WORDS);
  localparam int c_cnt_w  = $clog2(CON_DEPTH) + 1;

  logic [31:0]         r_ram [RAM_WORDS];
  logic [31:0]         r_cycle;
  logic [7:0]          r_drops;
  mmio_reg_e           w_sel;
  logic [c_ram_aw-1:0] w_ram_idx;
  logic                w_push;
  logic                w_pop;
  logic                w_reject;
  logic                w_full;
  logic                w_empty;
  logic [c_cnt_w-1:0]  w_count;
  logic [3:0]          w_occ;

  assign w_sel     = decode_addr(dmem_addr, RAM_WORDS);
  assign w_ram_idx = dmem_addr[c_ram_aw+1:2];
  assign w_push    = dmem_we && (w_sel == REG_CON_DATA);
  assign w_pop     = con_valid & con_ready;
  assign w_reject  = w_push & w_full & ~w_pop;
  assign w_occ     = 4'(w_count);
  assign con_valid = ~w_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (CON_DEPTH)
  ) u_con_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .wdata (dmem_wdata[7:0]),
    .pop   (w_pop),
    .rdata (con_data),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // RAM store; reset leaves contents alone but suppresses a coinciding store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (dmem_we && (w_sel == REG_RAM)) begin
      r_ram[w_ram_idx] <= dmem_wdata;
    end
  end

  // Free-running cycle counter; a software write wins over the increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_cycle <= '0;
    else if (dmem_we && (w_sel == REG_CYCLE)) r_cycle <= dmem_wdata;
    else                                     r_cycle <= r_cycle + 32'd1;
  end

  // Saturating count of console bytes lost to a full FIFO; any write clears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_drops <= '0;
    else if (dmem_we && (w_sel == REG_DROPS)) r_drops <= '0;
    else if (w_reject && (r_drops != 8'hFF))  r_drops <= r_drops + 8'd1;
  end

  // Side-effect-free read mux
  always_comb begin
    dmem_rdata = '0;
    case (w_sel)
      REG_RAM:        dmem_rdata = r_ram[w_ram_idx];
      REG_CON_STATUS: dmem_rdata = {24'd0, w_occ, 2'b00, w_empty, w_full};
      REG_CYCLE:      dmem_rdata = r_cycle;
      REG_DROPS:      dmem_rdata = {24'd0, r_drops};
      default:        dmem_rdata = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 1024, meaning data RAM depth in 32-bit words (power of two).
REQ-002 SHALL have parameter CON_DEPTH, default 4, meaning console FIFO depth in bytes (power of two, at least 2).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port dmem_addr  input  32  byte address from core.
REQ-006 SHALL have port dmem_wdata  input  32  store data from core.
REQ-007 SHALL have port dmem_we  input  1  store strobe; one word written per cycle it is high.
REQ-008 SHALL have port dmem_rdata  output  32  load data, combinational from dmem_addr.
REQ-009 SHALL have port con_valid  output  1  console byte available.
REQ-010 SHALL have port con_data  output  8  console byte at FIFO head; 0x00 when empty.
REQ-011 SHALL have port con_ready  input  1  console sink accepts byte.

Function
REQ-012 SHALL decode the address map as follows:
- RAM: 0x0000_0000 to 4*RAM_WORDS-1, indexed by addr[log2(RAM_WORDS)+1:2].
- CON_DATA: 0x1000_0000.
- CON_STATUS: 0x1000_0004.
- CYCLE: 0x1000_0008.
- DROPS: 0x1000_000C.
- Everything else is unmapped.
REQ-013 SHALL ignore addr[1:0] everywhere; accesses are word-only, with no byte enables.
REQ-014 SHALL return the addressed data on dmem_rdata in the same cycle (zero read latency); the core is single-cycle.
REQ-015 SHALL have no side effects on reads; the core drives dmem_addr every cycle.
REQ-016 SHALL update the RAM word on the clock edge when dmem_we=1 with a RAM address; a read of that word in the next cycle returns the new value.
REQ-017 SHALL read CON_DATA as 0x0000_0000. A write pushes dmem_wdata[7:0] into the console FIFO.
REQ-018 SHALL read CON_STATUS as bit0=full, bit1=empty, bits[7:4]=occupancy, all other bits 0. Writes are ignored.
REQ-019 SHALL have a 32-bit CYCLE counter:
- Increments by 1 every cycle and wraps 0xFFFF_FFFF to 0x0000_0000.
- A write loads dmem_wdata, and the write takes priority over the increment in that cycle.
REQ-020 SHALL have an 8-bit DROPS counter, zero-extended on read:
- Increments on each rejected push and saturates at 0xFF.
- A write of any value clears it to 0.
REQ-021 SHALL read unmapped addresses as 0x0000_0000 and ignore writes to them.
REQ-022 SHALL pop the FIFO when con_valid and con_ready are both high on a clock edge; con_valid = not empty.
REQ-023 SHALL accept a push when occupancy < CON_DEPTH, or when a pop occurs in the same cycle. Otherwise the push is rejected, the byte is discarded and DROPS increments.
REQ-024 SHALL change occupancy as follows when push and pop coincide:
- FIFO not empty: occupancy unchanged, and FIFO order is preserved.
- FIFO empty: no pop is possible, so the push simply lands.
REQ-025 SHALL wrap the FIFO read and write pointers modulo CON_DEPTH without a bubble.
REQ-026 SHALL hold con_data stable while con_valid=1 and con_ready=0.

Reset
REQ-027 SHALL, when rst_n=0, immediately and asynchronously:
- empty the FIFO and clear its pointers;
- drive con_valid=0 and con_data=0x00;
- clear CYCLE and DROPS to 0.
REQ-028 SHALL leave RAM contents uninitialised by reset; they are not required to be cleared.
REQ-029 SHALL, on reset mid-transfer, lose any unpopped FIFO bytes, and drop a store coinciding with reset assertion.
REQ-030 SHALL count CYCLE from 0 starting at the first rising edge after rst_n deasserts.

Structure
REQ-031 SHALL place in rv32_pkg the MMIO base constant and offsets (CON_DATA, CON_STATUS, CYCLE, DROPS) plus a mmio_reg_e enum for decode.
REQ-032 SHALL implement the console queue as one sub-module, sync_fifo, parameterised on width and depth, with push/pop/full/empty/count ports.
REQ-033 SHALL keep RAM, address decode, CYCLE and DROPS in dmem_responder itself.

Verification
REQ-034 SHALL cover RAM: store 0xCAFE_F00D at 0x0000_0010, then load 0x0000_0010 and 0x0000_0013 -> both return 0xCAFE_F00D; 0x0000_0014 is unaffected.
REQ-035 SHALL cover console ordering and backpressure: with con_ready=0, push 0x41,0x42,0x43,0x44,0x45 -> CON_STATUS=0x0000_0041 (full, count 4) and DROPS=1. With con_ready=1 the sink then receives 41,42,43,44, after which empty=1.
REQ-036 SHALL cover simultaneous push and pop on a full FIFO: with full FIFO and con_ready=1, push 0x5A -> accepted, count stays 4, DROPS unchanged, and 0x5A arrives last.
REQ-037 SHALL cover CYCLE wrap and write: write CYCLE=0xFFFF_FFFE -> next reads are 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000. A DROPS write of 0x1234 -> DROPS reads 0.
REQ-038 SHALL cover reset mid-operation: pull rst_n low with 3 bytes queued and CYCLE at 500 -> con_valid=0 with no clock edge, CYCLE=0, CON_STATUS=0x0000_0002. Reading unmapped 0x2000_0000 -> 0.
